// File: rtl/mem_port_arbiter.sv
// Shares one memory port among fetch, data and host; `define ARB_RR_EN for rotating priority (default host>data>fetch).
// Latency req->ack: MEM_LAT+2 cycles read, 2 cycles write; requesters wait by holding req until their ack.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          f_gnt,
    output logic          d_gnt,
    output logic          h_gnt,
    output logic          f_ack,
    output logic          d_ack,
    output logic          h_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_F    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_H    = 2'd3;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      win;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
`ifdef ARB_RR_EN
    logic [1:0]      last_q, last_d;
`endif

    // Winner among live requests; rotation starts after the previous winner in order h, d, f.
    always_comb begin
        win = OWN_NONE;
`ifdef ARB_RR_EN
        case (last_q)
            OWN_H: begin
                if (d_req)      win = OWN_D;
                else if (f_req) win = OWN_F;
                else if (h_req) win = OWN_H;
            end
            OWN_D: begin
                if (f_req)      win = OWN_F;
                else if (h_req) win = OWN_H;
                else if (d_req) win = OWN_D;
            end
            default: begin
                if (h_req)      win = OWN_H;
                else if (d_req) win = OWN_D;
                else if (f_req) win = OWN_F;
            end
        endcase
`else
        if (h_req)      win = OWN_H;
        else if (d_req) win = OWN_D;
        else if (f_req) win = OWN_F;
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (win != OWN_NONE) begin
                    owner_d = win;
                    state_d = ACCESS;
`ifdef ARB_RR_EN
                    last_d  = win;
`endif
                    case (win)
                        OWN_H: begin
                            we_d    = h_we;
                            addr_d  = h_addr;
                            wdata_d = h_wdata;
                        end
                        OWN_D: begin
                            we_d    = d_we;
                            addr_d  = d_addr;
                            wdata_d = d_wdata;
                        end
                        default: begin
                            we_d    = 1'b0;
                            addr_d  = f_addr;
                            wdata_d = '0;
                        end
                    endcase
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) last_q <= OWN_F;
        else     last_q <= last_d;
    end
`endif

    // owner_q is non-zero exactly from ACCESS through DONE, so it also drives the grants.
    assign f_gnt     = (owner_q == OWN_F);
    assign d_gnt     = (owner_q == OWN_D);
    assign h_gnt     = (owner_q == OWN_H);
    assign f_ack     = (state_q == DONE) && (owner_q == OWN_F);
    assign d_ack     = (state_q == DONE) && (owner_q == OWN_D);
    assign h_ack     = (state_q == DONE) && (owner_q == OWN_H);
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand sequences for priority/reset/latency, randomized traffic vs a transaction model.
module tb_mem_port_arbiter;
    localparam bit RR_EN =
`ifdef ARB_RR_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic CLB = 1'b1;
    always #5 clk = ~clk;

    logic       f_req, d_req, d_we, h_req, h_we;
    logic [7:0] f_addr, d_addr, d_wdata, h_addr, h_wdata;
    logic       f_gnt, d_gnt, h_gnt, f_ack, d_ack, h_ack;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_en, mem_we, busy;
    logic [1:0] owner;

    logic       h_req3, h_we3;
    logic [7:0] h_addr3, h_wdata3;
    logic       f_gnt3, d_gnt3, h_gnt3, f_ack3, d_ack3, h_ack3;
    logic [7:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic       mem_en3, mem_we3, busy3;
    logic [1:0] owner3;

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) u_dut (
        .clk(clk), .CLB(CLB),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .f_gnt(f_gnt), .d_gnt(d_gnt), .h_gnt(h_gnt),
        .f_ack(f_ack), .d_ack(d_ack), .h_ack(h_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .CLB(CLB),
        .f_req(1'b0), .f_addr(8'h00),
        .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(8'h00),
        .h_req(h_req3), .h_we(h_we3), .h_addr(h_addr3), .h_wdata(h_wdata3),
        .f_gnt(f_gnt3), .d_gnt(d_gnt3), .h_gnt(h_gnt3),
        .f_ack(f_ack3), .d_ack(d_ack3), .h_ack(h_ack3),
        .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
    );

    // Memory for the MEM_LAT=1 instance: unwritten locations read as addr^B5, idle cycles return EE.
    logic [7:0] mem_arr [256];
    bit         mem_wr  [256];
    logic [7:0] rpipe;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_wr[mem_addr]  <= 1'b1;
        end
        rpipe <= (mem_en && !mem_we) ? (mem_wr[mem_addr] ? mem_arr[mem_addr] : (mem_addr ^ 8'hB5)) : 8'hEE;
    end
    assign mem_rdata = rpipe;

    // Read-only 3-stage memory for the MEM_LAT=3 instance.
    logic [7:0] p0, p1, p2;
    always @(posedge clk) begin
        p0 <= (mem_en3 && !mem_we3) ? ((mem_addr3 == 8'h7F) ? 8'h99 : ~mem_addr3) : 8'h00;
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_rdata3 = p2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt_onehot0", 32'($onehot0({h_gnt, d_gnt, f_gnt})), 32'd1);
        chk("ack_onehot0", 32'($onehot0({h_ack, d_ack, f_ack})), 32'd1);
        chk("dut3_unused_ports", 32'({f_gnt3, d_gnt3, f_ack3, d_ack3}), 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Transaction-level reference: expected memory, last read value, last winner position (0=h,1=d,2=f).
    logic [7:0] exp_mem [256];
    bit         exp_wr  [256];
    logic [7:0] exp_last_rd;
    int         last_pos;
    int         ack_cyc, ack_cyc_prev;

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        return exp_wr[a] ? exp_mem[a] : (a ^ 8'hB5);
    endfunction

    function automatic logic [1:0] model_pick(input bit [3:0] p, input int last);
        int start;
        int pos;
        start = RR_EN ? (last + 1) % 3 : 0;
        for (int k = 0; k < 3; k++) begin
            pos = (start + k) % 3;
            if (p[3 - pos]) return 2'(3 - pos);
        end
        return 2'd0;
    endfunction

    task automatic drive(input logic [1:0] c, input logic we, input logic [7:0] a, input logic [7:0] wd);
        case (c)
            2'd1: begin f_req = 1'b1; f_addr = a; end
            2'd2: begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
            default: begin h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd; end
        endcase
    endtask

    task automatic drop(input logic [1:0] c);
        case (c)
            2'd1: f_req = 1'b0;
            2'd2: d_req = 1'b0;
            default: h_req = 1'b0;
        endcase
    endtask

    // Drops req and corrupts the winner's inputs after grant; the latched transaction must be unaffected.
    task automatic scramble(input logic [1:0] c);
        drop(c);
        case (c)
            2'd1: f_addr = 8'($urandom);
            2'd2: begin d_we = ~d_we; d_addr = 8'($urandom); d_wdata = 8'($urandom); end
            default: begin h_we = ~h_we; h_addr = 8'($urandom); h_wdata = 8'($urandom); end
        endcase
    endtask

    // Called at the negedge of an IDLE cycle with requests already driven; returns at the next IDLE negedge.
    task automatic do_txn(input logic [1:0] c, input logic we, input logic [7:0] a, input logic [7:0] wd,
                          input int lat, input logic [7:0] rd, input bit hold, input bit perturb);
        int n;
        int en_cnt;
        int we_cnt;
        logic [2:0] onehot;
        onehot = 3'd1 << (c - 2'd1);
        @(negedge clk);
        chk("access_owner", 32'(owner), 32'(c));
        chk("access_gnt", 32'({h_gnt, d_gnt, f_gnt}), 32'(onehot));
        chk("access_mem_en", 32'(mem_en), 32'd1);
        chk("access_mem_we", 32'(mem_we), 32'(we));
        chk("access_mem_addr", 32'(mem_addr), 32'(a));
        if (we) chk("access_mem_wdata", 32'(mem_wdata), 32'(wd));
        last_pos = 3 - int'(c);
        if (perturb) scramble(c);
        n = 1;
        en_cnt = 1;
        we_cnt = mem_we ? 1 : 0;
        while (n < 40 && {h_ack, d_ack, f_ack} == 3'b000) begin
            @(negedge clk);
            n++;
            if (mem_en) en_cnt++;
            if (mem_we) we_cnt++;
        end
        chk("ack_latency", 32'(n), 32'(lat));
        chk("ack_who", 32'({h_ack, d_ack, f_ack}), 32'(onehot));
        chk("done_gnt", 32'({h_gnt, d_gnt, f_gnt}), 32'(onehot));
        chk("done_rdata", 32'(rdata), 32'(rd));
        chk("mem_en_pulses", 32'(en_cnt), 32'd1);
        chk("mem_we_pulses", 32'(we_cnt), we ? 32'd1 : 32'd0);
        ack_cyc_prev = ack_cyc;
        ack_cyc = cyc;
        if (we) begin
            exp_mem[a] = wd;
            exp_wr[a]  = 1'b1;
        end else begin
            exp_last_rd = rd;
        end
        if (!hold) drop(c);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_owner", 32'(owner), 32'd0);
        chk("idle_ack", 32'({h_ack, d_ack, f_ack}), 32'd0);
    endtask

    task automatic do_reset();
        f_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
        CLB = 1'b1;
        @(negedge clk);
        CLB = 1'b0;
        last_pos = 2;
        exp_last_rd = 8'h00;
    endtask

    typedef struct {
        logic [1:0] who;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] rd;
    } vec_t;

    vec_t       tbl [11];
    int         exp6 [6];
    int         exp4 [4];
    bit [3:0]   pend;
    logic       p_we   [4];
    logic [7:0] p_addr [4];
    logic [7:0] p_wd   [4];
    logic [1:0] w;
    int         n3, en3, we3;

    initial begin
        tbl[0]  = '{2'd1, 1'b0, 8'h10, 8'h00, 3, 8'hA5};
        tbl[1]  = '{2'd2, 1'b1, 8'h20, 8'h3C, 2, 8'hA5};
        tbl[2]  = '{2'd1, 1'b0, 8'h20, 8'h00, 3, 8'h3C};
        tbl[3]  = '{2'd3, 1'b1, 8'h7F, 8'h99, 2, 8'h3C};
        tbl[4]  = '{2'd3, 1'b0, 8'h7F, 8'h00, 3, 8'h99};
        tbl[5]  = '{2'd2, 1'b0, 8'h10, 8'h00, 3, 8'hA5};
        tbl[6]  = '{2'd2, 1'b1, 8'h00, 8'hFF, 2, 8'hA5};
        tbl[7]  = '{2'd1, 1'b0, 8'h00, 8'h00, 3, 8'hFF};
        tbl[8]  = '{2'd3, 1'b1, 8'hFF, 8'h01, 2, 8'hFF};
        tbl[9]  = '{2'd2, 1'b0, 8'hFF, 8'h00, 3, 8'h01};
        tbl[10] = '{2'd1, 1'b0, 8'h33, 8'h00, 3, 8'h86};
        if (RR_EN) begin
            exp6 = '{3, 2, 1, 3, 2, 1};
            exp4 = '{2, 1, 2, 1};
        end else begin
            exp6 = '{3, 3, 3, 3, 3, 3};
            exp4 = '{2, 2, 2, 2};
        end

        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        h_req3 = 0; h_we3 = 0; h_addr3 = 0; h_wdata3 = 0;
        last_pos = 2; exp_last_rd = 8'h00; ack_cyc = 0; ack_cyc_prev = 0;

        // Reset state
        @(negedge clk);
        chk("reset_ctrl", 32'({busy, owner, h_gnt, d_gnt, f_gnt, h_ack, d_ack, f_ack, mem_en, mem_we}), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        CLB = 1'b0;

        // Single-requester vectors
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            do_txn(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].rd, 1'b0, 1'b0);
        end

        // All three raised together, each dropped after its ack
        do_reset();
        drive(2'd3, 1'b0, 8'h01, 8'h00);
        drive(2'd2, 1'b0, 8'h02, 8'h00);
        drive(2'd1, 1'b0, 8'h03, 8'h00);
        do_txn(2'd3, 1'b0, 8'h01, 8'h00, 3, exp_read(8'h01), 1'b0, 1'b0);
        do_txn(2'd2, 1'b0, 8'h02, 8'h00, 3, exp_read(8'h02), 1'b0, 1'b0);
        chk("ack_spacing_hd", 32'(ack_cyc - ack_cyc_prev), 32'd4);
        do_txn(2'd1, 1'b0, 8'h03, 8'h00, 3, exp_read(8'h03), 1'b0, 1'b0);
        chk("ack_spacing_df", 32'(ack_cyc - ack_cyc_prev), 32'd4);

        // All three held through their acks
        do_reset();
        drive(2'd3, 1'b0, 8'h01, 8'h00);
        drive(2'd2, 1'b0, 8'h02, 8'h00);
        drive(2'd1, 1'b0, 8'h03, 8'h00);
        for (int k = 0; k < 6; k++) begin
            w = 2'(exp6[k]);
            do_txn(w, 1'b0, 8'(4 - exp6[k]), 8'h00, 3, exp_read(8'(4 - exp6[k])), 1'b1, 1'b0);
        end
        h_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = 2'(exp4[k]);
            do_txn(w, 1'b0, 8'(4 - exp4[k]), 8'h00, 3, exp_read(8'(4 - exp4[k])), 1'b1, 1'b0);
        end

        // Reset during WAIT of a data read; held d_req must be re-granted afterwards
        f_req = 1'b0;
        d_addr = 8'h10;
        @(negedge clk);
        chk("pre_reset_owner", 32'(owner), 32'd2);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        CLB = 1'b1;
        #1;
        chk("async_reset_ctrl", 32'({busy, owner, h_gnt, d_gnt, f_gnt, h_ack, d_ack, f_ack, mem_en, mem_we}), 32'd0);
        chk("async_reset_data", 32'({rdata, mem_addr, mem_wdata}), 32'd0);
        last_pos = 2;
        exp_last_rd = 8'h00;
        @(negedge clk);
        chk("reset_no_ack", 32'({d_ack, busy}), 32'd0);
        CLB = 1'b0;
        do_txn(2'd2, 1'b0, 8'h10, 8'h00, 3, exp_read(8'h10), 1'b0, 1'b0);

        // Randomized traffic against the transaction model
        pend = '0;
        for (int it = 0; it < 300; it++) begin
            for (int c = 1; c <= 3; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c]   = 1'b1;
                    p_we[c]   = (c == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                    p_addr[c] = 8'($urandom_range(0, 15));
                    p_wd[c]   = 8'($urandom);
                    drive(2'(c), p_we[c], p_addr[c], p_wd[c]);
                end
            end
            if (pend == '0) begin
                @(negedge clk);
                chk("no_req_idle", 32'({busy, owner}), 32'd0);
            end else begin
                w = model_pick(pend, last_pos);
                do_txn(w, p_we[w], p_addr[w], p_wd[w], p_we[w] ? 2 : 3,
                       p_we[w] ? exp_last_rd : exp_read(p_addr[w]), 1'b0, $urandom_range(0, 3) == 0);
                pend[w] = 1'b0;
            end
        end

        // MEM_LAT=3 instance: host read then host write
        h_req3 = 1'b1; h_we3 = 1'b0; h_addr3 = 8'h7F;
        n3 = 0; en3 = 0;
        while (n3 < 40 && !(n3 > 0 && h_ack3)) begin
            @(negedge clk);
            n3++;
            if (mem_en3) en3++;
            if (n3 == 1) chk("lat3_access", 32'({h_gnt3, owner3, mem_addr3}), 32'({1'b1, 2'd3, 8'h7F}));
        end
        chk("lat3_read_latency", 32'(n3), 32'd5);
        chk("lat3_mem_en_pulses", 32'(en3), 32'd1);
        chk("lat3_rdata", 32'(rdata3), 32'h99);
        h_req3 = 1'b0;
        @(negedge clk);
        chk("lat3_idle", 32'(busy3), 32'd0);
        h_req3 = 1'b1; h_we3 = 1'b1; h_addr3 = 8'h40; h_wdata3 = 8'h5A;
        n3 = 0; we3 = 0;
        while (n3 < 40 && !(n3 > 0 && h_ack3)) begin
            @(negedge clk);
            n3++;
            if (mem_we3) begin
                we3++;
                chk("lat3_wr_bus", 32'({mem_addr3, mem_wdata3}), 32'({8'h40, 8'h5A}));
            end
        end
        chk("lat3_write_latency", 32'(n3), 32'd2);
        chk("lat3_we_pulses", 32'(we3), 32'd1);
        chk("lat3_rdata_after_write", 32'(rdata3), 32'h99);
        h_req3 = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port program/data memory between three requesters: instruction fetch (controller), data load/store (datapath), and host loader (external programming/debug).
- Sits between the controller/datapath and the memory macro.
- Serialises accesses with a req/ack handshake, selectable priority, and a configurable memory read latency.

Parameters:
AW, 8, address width
DW, 8, data width
MEM_LAT, 1, memory read latency in cycles (legal range 1..15)

Ports:
clk  input  1  system clock; all state changes on rising edge
CLB  input  1  reset, asynchronous, active-high
f_req  input  1  fetch request; held until f_ack
f_addr  input  AW  fetch address (reads only)
d_req  input  1  data request; held until d_ack
d_we  input  1  data write enable (1 = write)
d_addr  input  AW  data address
d_wdata  input  DW  data write value
h_req  input  1  host request; held until h_ack
h_we  input  1  host write enable
h_addr  input  AW  host address
h_wdata  input  DW  host write value
f_gnt, d_gnt, h_gnt  output  1 each  requester owns the memory; high ACCESS..DONE
f_ack, d_ack, h_ack  output  1 each  one-cycle completion pulse
rdata  output  DW  registered read data; valid while the matching ack is high
mem_en  output  1  memory strobe
mem_we  output  1  memory write
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle
busy  output  1  high in any state other than IDLE
owner  output  2  current owner: 0 none, 1 fetch, 2 data, 3 host

Behaviour:
- Reset (CLB=1, asynchronous):
  - State goes to IDLE.
  - All gnt, ack, mem_en, mem_we and busy go to 0.
  - rdata, mem_addr and mem_wdata go to 0. owner goes to 0.
  - Round-robin pointer goes to "fetch".
  - An in-flight transaction is dropped silently and no ack is issued. Requesters must re-request.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's we/addr/wdata into internal registers. Fetch always has we=0.
  - Set owner and the winner's gnt, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata are driven from the latched values.
  - Write: go to DONE.
  - Read: load the latency counter with MEM_LAT, then go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter equals 1, capture mem_rdata into rdata and go to DONE.
  - mem_en=0 throughout.
- DONE (exactly 1 cycle):
  - The winner's ack=1. rdata holds the read value; it is unchanged after a write.
  - Next state is IDLE.
  - gnt and owner clear on exit.
- No arbitration in DONE, so there is always one IDLE cycle between transactions.
- Latency from req sampled in IDLE to ack:
  - read: MEM_LAT+2 cycles
  - write: 2 cycles
- Priority (default): fixed, host > data > fetch.
- req sampled in IDLE only. Changes to req, addr or data after the grant are ignored, because the values are latched.
- Protocol violations:
  - A requester that drops req before its ack still gets its transaction completed and acked.
  - A requester that holds req through its ack re-arbitrates in the following IDLE.
- At most one gnt and at most one ack high in any cycle.
- Address and data have no wrap or arithmetic. Counter width is 4 bits.

Optional Feature:
- ARB_RR_EN defined:
  - Rotating priority. The search order starts at the requester after the last winner, in cyclic order h, d, f, h.
  - The pointer updates on each grant and resets to "fetch", so host has first priority after reset.
- ARB_RR_EN undefined: fixed priority host > data > fetch; no pointer register.

Test Plan (AW=8, DW=8, MEM_LAT=1 unless stated):
1. Fetch read: f_req=1, f_addr=0x10, mem[0x10]=0xA5, request sampled at edge 0:
   - cycle 1: f_gnt=1, mem_en=1, mem_addr=0x10, mem_we=0, owner=1
   - cycle 3: f_ack=1, rdata=0xA5
   - cycle 4: busy=0
2. Data write then fetch read:
   - d_we=1, d_addr=0x20, d_wdata=0x3C: one mem_en and mem_we pulse, d_ack 2 cycles after request.
   - Then fetch read of 0x20: rdata=0x3C.
3. Fixed priority: h_req, d_req and f_req all raised in the same cycle and each dropped after its ack:
   - grant order host, data, fetch
   - acks 4 cycles apart (all reads)
   - d and f held continuously: only data is ever granted.
4. ARB_RR_EN: all three reqs held high for 6 reads:
   - grant sequence h, d, f, h, d, f
   - owner sequence 3, 2, 1, 3, 2, 1
5. CLB pulsed during WAIT of a data read: all outputs are 0 immediately. d_ack is never asserted. After release, the held d_req is re-granted and completes normally.
6. MEM_LAT=3, host read of 0x7F holding 0x99: mem_en is high for 1 cycle, h_ack arrives 5 cycles after request, rdata=0x99.
